count_sequencer: RTL
====================

Name: count_sequencer

Overview:
- Control stage directly upstream of the modulo-N event counter; drives its `enable` and consumes its terminal-count flag (`flag32`).
- Turns an asynchronous start request into a run of exactly NUM_ROUNDS counter wraps, with enable optionally prescaled.
- Reports busy, a one-cycle done pulse and the completed round count to the top level.

Parameters:
- NUM_ROUNDS, 4: counter wraps per run; legal range ≥1.
- PRESCALE, 1: enable fires once every PRESCALE clocks in RUN; 1 gives continuous enable; legal range ≥1.
- DEBOUNCE_CYCLES, 16: stable-high clocks required on start; used only with SEQ_DEBOUNCE_EN.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- start_i  input  1  asynchronous start request, active-high level.
- stop_i  input  1  synchronous abort, active-high level.
- flag32  input  1  counter terminal-count flag (count == MAXIMUM_VALUE-1).
- enable  output  1  counter enable.
- busy  output  1  high in any state other than IDLE.
- done  output  1  one-cycle pulse at run completion.
- round_count  output  RW  completed wraps; RW = ceil_log2(NUM_ROUNDS+1).

Behaviour:
- Reset (reset==0, asynchronous):
  - state=IDLE; enable=0, busy=0, done=0, round_count=0.
  - Prescale counter and sync/edge registers cleared.
- Start conditioning:
  - start_i passes through a 2-FF synchroniser, then a rising-edge detector.
  - start_pulse goes high in the cycle after the second synchroniser flop first captures 1. Response is 2 edges from first sampled high, excluding debounce.
  - Holding start_i high produces one pulse only.
- States: IDLE, RUN, DONE.
- IDLE:
  - enable=0.
  - start_pulse → RUN; clears round_count and pre_cnt.
- RUN:
  - pre_cnt counts 0..PRESCALE-1 and wraps.
  - enable = (state==RUN) && (pre_cnt==PRESCALE-1), from registered state only.
  - A wrap is an edge where enable && flag32.
    - On a wrap, round_count increments.
    - If round_count was NUM_ROUNDS-1, go → DONE; round_count reaches NUM_ROUNDS.
  - stop_i sampled high → IDLE at that edge:
    - round_count holds its partial value.
    - enable may be high during the cycle stop_i is asserted.
  - stop_i and a final wrap on the same edge: stop wins; no DONE, round_count not incremented.
  - start_pulse in RUN or DONE is ignored (no restart).
- DONE:
  - Lasts exactly one cycle; done=1, enable=0.
  - Then → IDLE; round_count holds NUM_ROUNDS until the next start.
- Counter position at start is arbitrary: round 1 ends at the first flag32 wrap, not after a full MAXIMUM_VALUE enables.
- Width rules:
  - pre_cnt width = max(1, ceil_log2(PRESCALE)).
  - round_count never exceeds NUM_ROUNDS.
- Reset asserted mid-RUN: immediate return to reset values. enable drops asynchronously.

Optional Feature:
- Macro: SEQ_DEBOUNCE_EN.
- Defined:
  - After the synchroniser, a debounce counter requires the synchronised start to stay high for DEBOUNCE_CYCLES consecutive clocks before the edge detector sees a 1.
  - Any low sample clears the debounce counter.
  - Start latency = 2 + DEBOUNCE_CYCLES edges.
- Undefined: synchroniser + edge detect only; DEBOUNCE_CYCLES is ignored.

Decomposition:
- Package seq_pkg:
  - typedef enum logic [1:0] seq_state_t {IDLE, RUN, DONE}.
  - ceil_log2 function, shared with the counter's width calculation.
- Sub-module start_conditioner: synchroniser, edge detector and the SEQ_DEBOUNCE_EN debounce. Ports clk, reset, start_i, start_pulse.
- count_sequencer holds the FSM, prescaler and round counter.

Test Plan:
1. Reset: hold reset=0 with start_i=1 → enable=0, busy=0, done=0, round_count=0. Release reset with start_i held → one start_pulse, RUN.
2. NUM_ROUNDS=2, PRESCALE=1, counter MAX=32 starting at 0; pulse start_i → enable continuous for 64 cycles. round_count goes 1 at cycle 32, 2 at cycle 64. done pulses exactly one cycle; busy then falls.
3. PRESCALE=4 → enable high 1 cycle in 4. First wrap after 128 RUN clocks. No enable in DONE or IDLE.
4. stop_i asserted on the same edge as the final wrap → state IDLE, done never asserted, round_count=NUM_ROUNDS-1.
5. Second start_i pulse mid-RUN → ignored; round_count sequence unchanged. Asynchronous reset mid-RUN → all outputs return to 0 immediately.
6. With SEQ_DEBOUNCE_EN, DEBOUNCE_CYCLES=16:
   - 10-cycle start_i glitch → no RUN.
   - 20-cycle start_i high → RUN entered 18 edges after the first sampled high.

Source files
------------

// File: rtl/seq_pkg.sv
// seq_pkg: shared FSM state type and width helper for count_sequencer and the event counter
package seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } seq_state_t;

  // Smallest r with 2**r >= v; ceil_log2(1) is 0.
  function automatic int ceil_log2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/start_conditioner.sv
// start_conditioner: synchronises start_i and emits a single-cycle pulse on its (optionally debounced) rising edge; SEQ_DEBOUNCE_EN adds the debounce
module start_conditioner
  import seq_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic start_i,
  output logic start_pulse
);

  logic sync1_q;
  logic sync2_q;
  logic prev_q;
  logic level;

  // Two-flop synchroniser for the asynchronous start request
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= start_i;
      sync2_q <= sync1_q;
    end
  end

`ifdef SEQ_DEBOUNCE_EN
  localparam int DW = (ceil_log2(DEBOUNCE_CYCLES + 1) > 0) ? ceil_log2(DEBOUNCE_CYCLES + 1) : 1;

  logic [DW-1:0] deb_q;
  logic [DW-1:0] deb_d;

  // Count consecutive high samples, saturating once the level is trusted; any low sample restarts it
  always_comb begin
    deb_d = !sync2_q ? '0 : (deb_q == DW'(DEBOUNCE_CYCLES)) ? deb_q : deb_q + 1'b1;
  end

  // Debounce counter register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) deb_q <= '0;
    else        deb_q <= deb_d;
  end

  assign level = (deb_q == DW'(DEBOUNCE_CYCLES));
`else
  assign level = sync2_q;
`endif

  // Previous level for rising-edge detection, so a held request yields one pulse
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) prev_q <= 1'b0;
    else        prev_q <= level;
  end

  assign start_pulse = level & ~prev_q;

endmodule

// File: rtl/count_sequencer.sv
// count_sequencer: runs NUM_ROUNDS counter wraps per start with prescaled enable; optional start debounce via SEQ_DEBOUNCE_EN
module count_sequencer
  import seq_pkg::*;
#(
  parameter  int NUM_ROUNDS      = 4,
  parameter  int PRESCALE        = 1,
  parameter  int DEBOUNCE_CYCLES = 16,
  localparam int RW              = ceil_log2(NUM_ROUNDS + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start_i,
  input  logic          stop_i,
  input  logic          flag32,
  output logic          enable,
  output logic          busy,
  output logic          done,
  output logic [RW-1:0] round_count
);

  localparam int PW = (PRESCALE > 1) ? ceil_log2(PRESCALE) : 1;

  seq_state_t    state_q, state_d;
  logic [PW-1:0] pre_q, pre_d;
  logic [RW-1:0] round_q, round_d;
  logic          start_pulse;
  logic          last_pre;
  logic          wrap;

  start_conditioner #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_start (
    .clk        (clk),
    .reset      (reset),
    .start_i    (start_i),
    .start_pulse(start_pulse)
  );

  assign last_pre = (pre_q == PW'(PRESCALE - 1));
  assign enable   = (state_q == RUN) && last_pre;
  assign wrap     = enable && flag32;

  // Next state: start launches a run, stop aborts it (beating a coincident final wrap), the final wrap finishes it
  always_comb begin
    state_d = state_q;
    pre_d   = pre_q;
    round_d = round_q;
    unique case (state_q)
      IDLE: begin
        if (start_pulse) begin
          state_d = RUN;
          pre_d   = '0;
          round_d = '0;
        end
      end
      RUN: begin
        pre_d = last_pre ? '0 : pre_q + 1'b1;
        if (stop_i) begin
          state_d = IDLE;
        end else if (wrap) begin
          round_d = round_q + 1'b1;
          state_d = (round_q == RW'(NUM_ROUNDS - 1)) ? DONE : RUN;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State, prescaler and round counter registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      pre_q   <= '0;
      round_q <= '0;
    end else begin
      state_q <= state_d;
      pre_q   <= pre_d;
      round_q <= round_d;
    end
  end

  assign busy        = (state_q != IDLE);
  assign done        = (state_q == DONE);
  assign round_count = round_q;

endmodule
